// File: rtl/stopwatch_mmss_if.sv
// stopwatch_mmss_if: command inputs and display outputs of the MM:SS stopwatch.
interface stopwatch_mmss_if;
    logic       slow_clk;
    logic       start_stop;
    logic       clear;
    logic       tick;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;

    modport master (
        output slow_clk, start_stop, clear,
        input  tick, sec_ones, sec_tens, min_ones, min_tens, running, rollover
    );

    modport slave (
        input  slow_clk, start_stop, clear,
        output tick, sec_ones, sec_tens, min_ones, min_tens, running, rollover
    );
endinterface

// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: MM:SS BCD stopwatch advanced by synchronized rising edges of slow_clk,
// controlled by start_stop/clear pulses through an IDLE/RUN/PAUSE FSM.
module stopwatch_mmss (
    input  logic            clk_in,
    input  logic            rst_n,
    stopwatch_mmss_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state_q, state_d;
    logic       s1_q, s2_q, s3_q, tick_q, rollover_q, running_q;
    logic       tick_d, rollover_d, count, c0, c1, c2;
    logic [3:0] so_q, st_q, mo_q, mt_q;
    logic [3:0] so_d, st_d, mo_d, mt_d;

    always_comb begin
        tick_d     = s2_q & ~s3_q;
        count      = tick_d && state_q == RUN && !sw.clear;
        c0         = so_q == 4'd9;
        c1         = c0 && st_q == 4'd5;
        c2         = c1 && mo_q == 4'd9;
        so_d       = sw.clear ? 4'd0 : count      ? (c0 ? 4'd0 : so_q + 4'd1) : so_q;
        st_d       = sw.clear ? 4'd0 : count && c0 ? (st_q == 4'd5 ? 4'd0 : st_q + 4'd1) : st_q;
        mo_d       = sw.clear ? 4'd0 : count && c1 ? (mo_q == 4'd9 ? 4'd0 : mo_q + 4'd1) : mo_q;
        mt_d       = sw.clear ? 4'd0 : count && c2 ? (mt_q == 4'd5 ? 4'd0 : mt_q + 4'd1) : mt_q;
        rollover_d = count && c2 && mt_q == 4'd5;
        // clear outranks start_stop; start_stop toggles RUN against IDLE/PAUSE
        state_d    = sw.clear ? IDLE : sw.start_stop ? (state_q == RUN ? PAUSE : RUN) : state_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
            running_q  <= 1'b0;
            state_q    <= IDLE;
            so_q       <= 4'd0;
            st_q       <= 4'd0;
            mo_q       <= 4'd0;
            mt_q       <= 4'd0;
        end else begin
            s1_q       <= sw.slow_clk;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            tick_q     <= tick_d;
            rollover_q <= rollover_d;
            running_q  <= state_d == RUN;
            state_q    <= state_d;
            so_q       <= so_d;
            st_q       <= st_d;
            mo_q       <= mo_d;
            mt_q       <= mt_d;
        end
    end

    assign sw.tick     = tick_q;
    assign sw.rollover = rollover_q;
    assign sw.running  = running_q;
    assign sw.sec_ones = so_q;
    assign sw.sec_tens = st_q;
    assign sw.min_ones = mo_q;
    assign sw.min_tens = mt_q;
endmodule

// File: tb/tb_stopwatch_mmss.sv
// tb_stopwatch_mmss: scoreboard bench; a seconds-count model predicts each tick's display,
// and a monitor checks the DUT whenever it presents a tick.
module tb_stopwatch_mmss;
    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    stopwatch_mmss_if sw();
    stopwatch_mmss dut (.clk_in(clk_in), .rst_n(rst_n), .sw(sw.slave));

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [15:0] d;
        logic        run;
        logic        roll;
    } exp_t;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          total   = 0;
    int          mstate  = M_IDLE;
    logic [15:0] prev    = 16'h0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] bcd(int t);
        int m = t / 60;
        int s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] disp();
        return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
    endfunction

    function automatic void model_step(bit tk, bit ss, bit clr);
        bit roll = 1'b0;
        if (clr) begin
            total  = 0;
            mstate = M_IDLE;
        end else begin
            if (tk && mstate == M_RUN) begin
                roll  = total == 3599;
                total = (total + 1) % 3600;
            end
            if (ss) mstate = (mstate == M_RUN) ? M_PAUSE : M_RUN;
        end
        if (tk) exp_q.push_back('{bcd(total), mstate == M_RUN, roll});
    endfunction

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n) begin
            if (sw.tick) begin
                if (exp_q.size() == 0) chk("unexpected_tick", 32'(sw.tick), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("digits", 32'(disp()), 32'(e.d));
                    chk("running", 32'(sw.running), 32'(e.run));
                    chk("rollover", 32'(sw.rollover), 32'(e.roll));
                end
            end else begin
                chk("rollover_idle", 32'(sw.rollover), 32'd0);
                if (disp() != prev) chk("digits_off_tick", 32'(disp()), 32'd0);
            end
        end
        prev = disp();
    end

    task automatic period(input bit ss, input bit clr);
        @(negedge clk_in);
        sw.slow_clk = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("tick_early", 32'(sw.tick), 32'd0);
        sw.start_stop = ss;
        sw.clear      = clr;
        model_step(1'b1, ss, clr);
        @(negedge clk_in);
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.slow_clk   = 1'b0;
        @(negedge clk_in);
        chk("tick_width", 32'(sw.tick), 32'd0);
        repeat ($urandom_range(2, 4)) @(negedge clk_in);
    endtask

    task automatic cmd(input bit ss, input bit clr);
        @(negedge clk_in);
        sw.start_stop = ss;
        sw.clear      = clr;
        @(negedge clk_in);
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        model_step(1'b0, ss, clr);
        chk("running_cmd", 32'(sw.running), 32'(mstate == M_RUN));
    endtask

    task automatic run_to(input int target);
        while (total != target) period(1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tick"}, 32'(sw.tick), 32'd0);
        chk({tag, "_run"}, 32'(sw.running), 32'd0);
        chk({tag, "_roll"}, 32'(sw.rollover), 32'd0);
        chk({tag, "_digits"}, 32'(disp()), 32'd0);
    endtask

    initial begin
        int r;
        sw.slow_clk   = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        #12 check_zero("reset");
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        check_zero("post_reset");

        period(1'b0, 1'b0);
        cmd(1'b1, 1'b0);
        repeat (75) period(1'b0, 1'b0);
        chk("disp_01_15", 32'(disp()), 32'h0115);
        chk("run_01_15", 32'(sw.running), 32'd1);

        run_to(3598);
        chk("disp_59_58", 32'(disp()), 32'h5958);
        period(1'b0, 1'b0);
        period(1'b0, 1'b0);
        chk("disp_wrap", 32'(disp()), 32'h0000);

        run_to(10);
        period(1'b1, 1'b0);
        chk("pause_00_11", 32'(disp()), 32'h0011);
        chk("pause_running", 32'(sw.running), 32'd0);
        repeat (5) period(1'b0, 1'b0);
        chk("pause_hold", 32'(disp()), 32'h0011);
        cmd(1'b1, 1'b0);
        period(1'b0, 1'b0);
        chk("resume_00_12", 32'(disp()), 32'h0012);

        run_to(207);
        chk("disp_03_27", 32'(disp()), 32'h0327);
        period(1'b1, 1'b1);
        chk("clear_digits", 32'(disp()), 32'h0000);
        chk("clear_running", 32'(sw.running), 32'd0);

        cmd(1'b1, 1'b0);
        run_to(754);
        chk("disp_12_34", 32'(disp()), 32'h1234);
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        total       = 0;
        mstate      = M_IDLE;
        sw.slow_clk = 1'b1;
        @(negedge clk_in);
        exp_q.push_back('{16'h0000, 1'b0, 1'b0});
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        sw.slow_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("release_tick_done", 32'(exp_q.size()), 32'd0);
        period(1'b0, 1'b0);
        chk("release_idle", 32'(disp()), 32'h0000);
        cmd(1'b1, 1'b0);
        period(1'b0, 1'b0);
        chk("release_count", 32'(disp()), 32'h0001);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0) cmd(1'b1, 1'b0);
            else if (r == 1) cmd(1'b0, 1'b1);
            else if (r == 2) period(1'b1, 1'b0);
            else if (r == 3) period(1'b0, 1'b1);
            else if (r == 4) period(1'b1, 1'b1);
            else period(1'b0, 1'b0);
        end

        repeat (4) @(negedge clk_in);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_mmss.md
STOPWATCH_MMSS -- requirements
Module: stopwatch_mmss

Interface
REQ-001 The module SHALL use one clock and SHALL have an asynchronous, active-low reset.
REQ-002 The module SHALL have no parameters; the synchronizer depth SHALL be fixed at 2 flops.
REQ-003 clk_in  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 slow_clk  input  1  divided clock from the upstream clock divider, treated as asynchronous data, never as a clock.
REQ-006 start_stop  input  1  synchronous one-cycle command pulse that toggles between running and paused.
REQ-007 clear  input  1  synchronous one-cycle command pulse that returns the block to zero and idle.
REQ-008 tick  output  1  one-cycle pulse per synchronized rising edge of slow_clk.
REQ-009 sec_ones  output  4  BCD seconds units, range 0-9.
REQ-010 sec_tens  output  4  BCD seconds tens, range 0-5.
REQ-011 min_ones  output  4  BCD minutes units, range 0-9.
REQ-012 min_tens  output  4  BCD minutes tens, range 0-5.
REQ-013 running  output  1  high while in state RUN.
REQ-014 rollover  output  1  one-cycle pulse on wrap from 59:59 to 00:00.

Function
REQ-015 slow_clk SHALL pass through a 2-flop synchronizer (s1, s2), followed by a history flop s3.
REQ-016 tick SHALL be a registered copy of (s2 & ~s3): it SHALL be high for exactly one clk_in cycle, beginning at the 3rd rising edge of clk_in at which slow_clk is sampled high after having been sampled low.
REQ-017 tick SHALL be generated in every state, including IDLE and PAUSE.
REQ-018 The FSM SHALL have three states: IDLE, RUN, PAUSE; running SHALL equal (state==RUN).
REQ-019 FSM transitions on start_stop SHALL be: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-020 clear SHALL force IDLE from any state and SHALL zero all digits on the same edge.
REQ-021 clear SHALL take priority over start_stop and over a counted tick arriving in the same cycle.
REQ-022 The digits SHALL advance by one second on the same edge that sets tick, only when the current (pre-edge) state is RUN and clear is low.
REQ-023 A tick coinciding with start_stop SHALL be counted if the state is RUN and SHALL NOT be counted if the state is IDLE or PAUSE.
REQ-024 Digit carry SHALL be: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0 completes the wrap.
REQ-025 On a counted tick at 59:59, all digits SHALL become 00:00 and rollover SHALL be high for that one cycle.
REQ-026 Counting SHALL continue after a wrap.
REQ-027 Digits SHALL hold their values in PAUSE, and SHALL hold 00:00 in IDLE.
REQ-028 All outputs SHALL be registered.
REQ-029 Digits SHALL never leave their BCD ranges.

Reset
REQ-030 While rst_n=0: s1, s2, s3, tick, rollover, running and all digits SHALL be 0, and state SHALL be IDLE, asynchronously.
REQ-031 If slow_clk is high at reset release, one tick SHALL be produced.
REQ-032 That post-reset tick SHALL NOT be counted, because the state is IDLE.
REQ-033 Reset asserted mid-count SHALL discard the time and state immediately, with no pending tick or rollover pulse after release.

Verification
REQ-034 Reset with slow_clk=0, then a slow_clk 0->1 step -> tick high exactly 3 edges later for 1 cycle; digits stay 00:00 (IDLE).
REQ-035 start_stop pulse, then 75 slow_clk periods -> running=1 and display 01:15; each digit changes only on a tick edge.
REQ-036 Preload by running to 59:58, then 2 ticks -> 59:59, then 00:00 with rollover=1 for exactly one cycle.
REQ-037 In RUN at 00:10, start_stop coincident with tick -> 00:11 and state PAUSE; 5 further ticks -> 00:11 held; start_stop -> RUN resumes from 00:11.
REQ-038 clear coincident with start_stop and tick while in RUN at 03:27 -> 00:00, running=0, state IDLE.
REQ-039 rst_n pulsed low mid-cycle while in RUN at 12:34 -> all outputs 0 immediately; after release the count stays at 00:00 until start_stop.
